// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over CH colour channels with a two-stage
// valid/ready pipeline: S1 holds raw signed kernel sums, S2 holds the
// normalised, clamped pixels presented downstream.
module conv3x3_stream #(
  parameter int unsigned CH = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 16
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [CH*9*DW-1:0]   win_data,
  input  logic [1:0]           win_mode,
  input  logic                 win_valid,
  output logic                 win_ready,
  output logic [CH*OW-1:0]     pixel_out,
  output logic                 conv_valid,
  input  logic                 out_ready,
  output logic [15:0]          pix_count
);

  localparam int unsigned TAPS = 9;
  localparam int unsigned SW   = DW + 5;
  localparam int unsigned CW   = 16;

  typedef logic signed [SW-1:0] sum_t;

  typedef enum logic [1:0] {
    MODE_GAUSS = 2'b00,
    MODE_IDENT = 2'b01,
    MODE_SHARP = 2'b10,
    MODE_EDGE  = 2'b11
  } mode_e;

  localparam sum_t SAT_MAX = sum_t'((2 ** DW) - 1);

  // Handshake / advance terms
  logic s2_adv_c;
  logic s1_adv_c;
  logic win_xfer_c;
  logic out_xfer_c;

  // S1 stage: raw sums plus the mode they were computed under
  logic  s1_valid;
  mode_e s1_mode;
  sum_t  s1_sum [CH];

  // Combinational datapath
  sum_t           tap_c     [CH][TAPS];
  sum_t           raw_sum_c [CH];
  sum_t           mag_c     [CH];
  logic [DW-1:0]  res_c     [CH];
  logic [CH*OW-1:0] norm_c;

  // S2 may move when it is empty or its contents are being taken;
  // S1 may move when it is empty or S2 is about to take its contents.
  assign s2_adv_c   = !conv_valid || out_ready;
  assign s1_adv_c   = !s1_valid || s2_adv_c;
  assign win_ready  = s1_adv_c;
  assign win_xfer_c = win_valid && win_ready;
  assign out_xfer_c = conv_valid && out_ready;

  // Unpack taps per channel, zero-extended into the signed sum width
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < TAPS; k++) begin
        tap_c[c][k] = sum_t'(win_data[(c*TAPS+k)*DW +: DW]);
      end
    end
  end

  // Raw signed kernel sums; taps index 1/3/5/7 are N/W/E/S, 4 is centre
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      raw_sum_c[c] = '0;
      case (mode_e'(win_mode))
        MODE_GAUSS: raw_sum_c[c] = tap_c[c][0] + tap_c[c][2] + tap_c[c][6] + tap_c[c][8]
                                 + ((tap_c[c][1] + tap_c[c][3] + tap_c[c][5] + tap_c[c][7]) <<< 1)
                                 + (tap_c[c][4] <<< 2);
        MODE_IDENT: raw_sum_c[c] = tap_c[c][4];
        MODE_SHARP: raw_sum_c[c] = (tap_c[c][4] <<< 2) + tap_c[c][4]
                                 - tap_c[c][1] - tap_c[c][3] - tap_c[c][5] - tap_c[c][7];
        MODE_EDGE:  raw_sum_c[c] = (tap_c[c][4] <<< 2)
                                 - tap_c[c][1] - tap_c[c][3] - tap_c[c][5] - tap_c[c][7];
        default:    raw_sum_c[c] = '0;
      endcase
    end
  end

  // S1 register: capture sums and mode together on each window transfer
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_GAUSS;
      for (int c = 0; c < CH; c++) begin
        s1_sum[c] <= '0;
      end
    end else if (s1_adv_c) begin
      s1_valid <= win_valid;
      if (win_xfer_c) begin
        s1_mode <= mode_e'(win_mode);
        for (int c = 0; c < CH; c++) begin
          s1_sum[c] <= raw_sum_c[c];
        end
      end
    end
  end

  // Normalise S1 sums by their captured mode: shift, pass, or clamp
  always_comb begin
    norm_c = '0;
    for (int c = 0; c < CH; c++) begin
      mag_c[c] = (s1_sum[c] < 0) ? -s1_sum[c] : s1_sum[c];
      res_c[c] = '0;
      case (s1_mode)
        MODE_GAUSS: res_c[c] = DW'(s1_sum[c] >>> 4);
        MODE_IDENT: res_c[c] = DW'(s1_sum[c]);
        MODE_SHARP: begin
          if (s1_sum[c] < 0) begin
            res_c[c] = '0;
          end else if (s1_sum[c] > SAT_MAX) begin
            res_c[c] = '1;
          end else begin
            res_c[c] = DW'(s1_sum[c]);
          end
        end
        MODE_EDGE: begin
          if (mag_c[c] > SAT_MAX) begin
            res_c[c] = '1;
          end else begin
            res_c[c] = DW'(mag_c[c]);
          end
        end
        default: res_c[c] = '0;
      endcase
      norm_c[c*OW +: OW] = OW'(res_c[c]);
    end
  end

  // S2 register: result held while downstream stalls, bubble clears valid
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      conv_valid <= 1'b0;
      pixel_out  <= '0;
    end else if (s2_adv_c) begin
      conv_valid <= s1_valid;
      if (s1_valid) begin
        pixel_out <= norm_c;
      end
    end
  end

  // Count of results handed downstream, wraps naturally
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pix_count <= '0;
    end else if (out_xfer_c) begin
      pix_count <= pix_count + CW'(1);
    end
  end

endmodule
